// File: rtl/parallel_to_serial.sv
// parallel_to_serial: takes width-bit words on a valid/ready handshake and
// emits them one bit per cycle, LSB first, with no gap between back-to-back
// words.
// Ports: clk, rst (sync, active-high), parallel_valid/parallel_ready/
// parallel_data (word in), serial_valid/serial_data (bit out, registered),
// serial_ready (only with PARALLEL_TO_SERIAL_BACKPRESSURE_EN), busy.
// Optional feature macro: PARALLEL_TO_SERIAL_BACKPRESSURE_EN adds the
// serial_ready input so the downstream can stall the bit stream.
module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  output logic             serial_valid,
  output logic             serial_data,
`ifdef PARALLEL_TO_SERIAL_BACKPRESSURE_EN
  input  logic             serial_ready,
`endif
  output logic             busy
);

  localparam int cnt_w = ($clog2(width) > 0) ? $clog2(width) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(width - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [width-1:0] shreg;
  logic [width-1:0] shnext;
  logic [cnt_w-1:0] cnt;
  logic             adv;
  logic             last;
  logic             accept;

`ifdef PARALLEL_TO_SERIAL_BACKPRESSURE_EN
  assign adv = serial_ready;
`else
  assign adv = 1'b1;
`endif

  assign last   = (state == SHIFT) && (cnt == cnt_last);
  assign parallel_ready = !rst &&
                          ((state == IDLE) || (last && adv));
  assign accept = parallel_valid && parallel_ready;
  assign busy   = serial_valid;

  // shreg is shifted right as bits go out, so the
  // next bit to emit is always at position 0 after the shift.
  assign shnext = shreg >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      serial_valid <= 1'b0;
      serial_data  <= 1'b0;
    end else if (accept) begin
      state        <= SHIFT;
      shreg        <= parallel_data;
      cnt          <= '0;
      serial_valid <= 1'b1;
      serial_data  <= parallel_data[0];
    end else if (state == SHIFT && adv) begin
      if (last) begin
        state        <= IDLE;
        cnt          <= '0;
        serial_valid <= 1'b0;
        serial_data  <= 1'b0;
      end else begin
        shreg       <= shnext;
        cnt         <= cnt + cnt_w'(1);
        serial_data <= shnext[0];
      end
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: vector table, hand sequences and a random
// round-trip against a queue-based model for parallel_to_serial.
module tb_parallel_to_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       pv;
  logic       pr;
  logic [7:0] pd;
  logic       sv;
  logic       sd;
  logic       bz;
  logic       sready;

  logic pv1;
  logic pr1;
  logic pd1;
  logic sv1;
  logic sd1;
  logic bz1;

  int checks   = 0;
  int failures = 0;

  parallel_to_serial #(.width(8)) dut (
    .clk(clk),
    .rst(rst),
    .parallel_valid(pv),
    .parallel_ready(pr),
    .parallel_data(pd),
    .serial_valid(sv),
    .serial_data(sd),
`ifdef PARALLEL_TO_SERIAL_BACKPRESSURE_EN
    .serial_ready(sready),
`endif
    .busy(bz)
  );

  parallel_to_serial #(.width(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .parallel_valid(pv1),
    .parallel_ready(pr1),
    .parallel_data(pd1),
    .serial_valid(sv1),
    .serial_data(sd1),
`ifdef PARALLEL_TO_SERIAL_BACKPRESSURE_EN
    .serial_ready(sready),
`endif
    .busy(bz1)
  );

  typedef struct {
    logic [7:0] word;
    logic [0:7] seq;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] w,
                           input logic [0:7] seq);
    int t;
    pv = 1'b1;
    pd = w;
    #1;
    t = 0;
    while (!pr && t < 50) begin
      step();
      t++;
    end
    chk("send_ready", 32'(pr), 32'd1);
    step();
    pv = 1'b0;
    pd = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("send_valid", 32'(sv), 32'd1);
      chk("send_busy", 32'(bz), 32'd1);
      chk("send_bit", 32'(sd), 32'(seq[i]));
      chk("send_pready", 32'(pr), 32'(i == 7));
      step();
    end
    chk("send_idle_valid", 32'(sv), 32'd0);
    chk("send_idle_data", 32'(sd), 32'd0);
    chk("send_idle_pready", 32'(pr), 32'd1);
  endtask

  initial begin
    logic [7:0] bw[3];
    logic       bq[$];
    logic [7:0] expq[$];
    logic [7:0] acc_word;
    logic [7:0] ew;
    logic [0:2] s1;
    logic       acc;
    int sent;
    int got;
    int bits;
    int nb;
    int cyc;
    int idx;

    vecs[0] = '{word: 8'hA5, seq: 8'b10100101};
    vecs[1] = '{word: 8'h0F, seq: 8'b11110000};
    vecs[2] = '{word: 8'hC3, seq: 8'b11000011};
    vecs[3] = '{word: 8'h3C, seq: 8'b00111100};

    rst    = 1'b1;
    pv     = 1'b0;
    pd     = 8'h00;
    pv1    = 1'b0;
    pd1    = 1'b0;
    sready = 1'b1;
    step();
    step();
    chk("rst_svalid", 32'(sv), 32'd0);
    chk("rst_sdata", 32'(sd), 32'd0);
    chk("rst_busy", 32'(bz), 32'd0);
    chk("rst_pready", 32'(pr), 32'd0);
    chk("rst_pready_w1", 32'(pr1), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_pready", 32'(pr), 32'd1);

    for (int v = 0; v < 4; v++)
      send_word(vecs[v].word, vecs[v].seq);

    // back-to-back words, valid held high
    bw[0] = 8'h01;
    bw[1] = 8'hFF;
    bw[2] = 8'h3C;
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 8; b++)
        bq.push_back(bw[w][b]);
    for (int c = 0; c <= 24; c++) begin
      pv = (c <= 16);
      pd = bw[(c < 24) ? c / 8 : 2];
      #1;
      chk("b2b_pready", 32'(pr), 32'(c % 8 == 0));
      if (c > 0) begin
        chk("b2b_valid", 32'(sv), 32'd1);
        chk("b2b_bit", 32'(sd), 32'(bq[c-1]));
      end
      step();
    end
    pv = 1'b0;
    chk("b2b_end_valid", 32'(sv), 32'd0);

    // reset in the middle of 8'hF0
    pv = 1'b1;
    pd = 8'hF0;
    #1;
    step();
    pv = 1'b0;
    step();
    step();
    step();
    chk("mid_bit3_valid", 32'(sv), 32'd1);
    chk("mid_bit3", 32'(sd), 32'd0);
    rst = 1'b1;
    pv  = 1'b1;
    pd  = 8'hAA;
    #1;
    chk("mid_rst_pready", 32'(pr), 32'd0);
    step();
    chk("mid_rst_valid", 32'(sv), 32'd0);
    step();
    chk("mid_rst_noaccept", 32'(sv), 32'd0);
    rst = 1'b0;
    pv  = 1'b0;
    step();
    chk("mid_after_valid", 32'(sv), 32'd0);
    send_word(8'h0F, 8'b11110000);

`ifdef PARALLEL_TO_SERIAL_BACKPRESSURE_EN
    pv     = 1'b1;
    pd     = 8'hC3;
    sready = 1'b0;
    #1;
    chk("bp_accept", 32'(pr), 32'd1);
    step();
    pv  = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 64) begin
      sready = (cyc % 2 == 0);
      #1;
      chk("bp_valid", 32'(sv), 32'd1);
      chk("bp_bit", 32'(sd), 32'(vecs[2].seq[idx]));
      chk("bp_pready", 32'(pr), 32'(idx == 7 && sready));
      if (sready)
        idx++;
      step();
      cyc++;
    end
    chk("bp_count", 32'(idx), 32'd8);
    chk("bp_end_valid", 32'(sv), 32'd0);
    sready = 1'b1;
`endif

    // width==1 instance
    s1 = 3'b101;
    for (int c = 0; c <= 3; c++) begin
      pv1 = (c < 3);
      pd1 = (c < 3) ? s1[c] : 1'b0;
      #1;
      chk("w1_pready", 32'(pr1), 32'd1);
      if (c > 0) begin
        chk("w1_valid", 32'(sv1), 32'd1);
        chk("w1_bit", 32'(sd1), 32'(s1[c-1]));
      end
      step();
    end
    pv1 = 1'b0;
    chk("w1_end_valid", 32'(sv1), 32'd0);

    // random words reassembled from the serial stream
    sent = 0;
    got  = 0;
    bits = 0;
    nb   = 0;
    cyc  = 0;
    acc_word = '0;
    pv   = 1'b0;
    while (got < 100 && cyc < 5000) begin
`ifdef PARALLEL_TO_SERIAL_BACKPRESSURE_EN
      sready = 1'($urandom_range(1));
`endif
      #1;
      if (sv && sready) begin
        acc_word[nb] = sd;
        nb++;
        bits++;
        if (nb == 8) begin
          nb = 0;
          got++;
          if (expq.size() > 0) begin
            ew = expq.pop_front();
            chk("rand_word", 32'(acc_word), 32'(ew));
          end else begin
            chk("rand_unexpected", 32'(acc_word), 32'hFFFF_FFFF);
          end
        end
      end
      if (!pv && sent < 100 && $urandom_range(3) != 0) begin
        pd = 8'($urandom);
        pv = 1'b1;
      end
      #1;
      acc = pv && pr;
      if (acc) begin
        expq.push_back(pd);
        sent++;
      end
      step();
      if (acc) begin
        pv = 1'b0;
        pd = 8'($urandom);
      end
      cyc++;
    end
    pv = 1'b0;
    sready = 1'b1;
    chk("rand_words", 32'(got), 32'd100);
    chk("rand_bits", 32'(bits), 32'd800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
